// File: rtl/onehot_encoder_seq.sv
// Handshaked N-bit set-bit enumerator: emits one index per accepted beat in priority order.
// A vector accepted at edge t appears on out_* after edge t; out_ready low freezes all outputs and blocks new input.
module onehot_encoder_seq #(
   parameter int  N           = 8,
   parameter int  MSB_FIRST   = 0,
   parameter int  ONEHOT_ONLY = 0,
   localparam int IDX_W       = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_vec,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_last,
   output logic             out_multi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             zero_err
);

   logic [N-1:0]     pending_q, pending_d;
   logic             multi_q, multi_d;
   logic             zero_err_q, zero_err_d;
   logic [N-1:0]     sel_mask;
   logic [IDX_W-1:0] sel_idx;
   logic             single_hot;
   logic             accept;
   logic             pop;

   // Scan from lowest to highest priority so the final hit is the winner.
   always_comb begin
      sel_mask = '0;
      sel_idx  = '0;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < N; i++) begin
            if (pending_q[i]) begin
               sel_idx     = IDX_W'(i);
               sel_mask    = '0;
               sel_mask[i] = 1'b1;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
               sel_idx     = IDX_W'(i);
               sel_mask    = '0;
               sel_mask[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      single_hot = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
      out_valid  = (pending_q != '0);
      out_idx    = sel_idx;
      out_multi  = multi_q;
      zero_err   = zero_err_q;
      out_last   = (ONEHOT_ONLY != 0) ? out_valid : single_hot;
      pop        = out_valid && out_ready;
      in_ready   = !out_valid || (pop && out_last);
      accept     = in_valid && in_ready;
   end

   // A load on the final pop overrides the clear, giving bubble-free back-to-back vectors.
   always_comb begin
      pending_d  = pending_q;
      multi_d    = multi_q;
      zero_err_d = 1'b0;
      if (pop) begin
         pending_d = (ONEHOT_ONLY != 0) ? '0 : (pending_q & ~sel_mask);
      end
      if (accept) begin
         pending_d  = in_vec;
         multi_d    = ((in_vec & (in_vec - N'(1))) != '0);
         zero_err_d = (in_vec == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_q  <= '0;
         multi_q    <= 1'b0;
         zero_err_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         multi_q    <= multi_d;
         zero_err_q <= zero_err_d;
      end
   end

endmodule

// File: tb/tb_onehot_encoder_seq.sv
// Bench for onehot_encoder_seq: three configurations driven from one initial block, beats scored against a queue.
module tb_onehot_encoder_seq;

   typedef struct packed {
      logic [7:0] idx;
      logic       last;
      logic       multi;
   } beat_t;

   logic clk;
   logic rst_n;

   // a: N=8 LSB-first enumerate; b: N=8 MSB-first one-hot-only; c: N=16 LSB-first
   logic [7:0]  a_vec;  logic a_in_valid, a_in_ready, a_out_last, a_out_multi, a_out_valid, a_out_ready, a_zero_err;
   logic [2:0]  a_out_idx;
   logic [7:0]  b_vec;  logic b_in_valid, b_in_ready, b_out_last, b_out_multi, b_out_valid, b_out_ready, b_zero_err;
   logic [2:0]  b_out_idx;
   logic [15:0] c_vec;  logic c_in_valid, c_in_ready, c_out_last, c_out_multi, c_out_valid, c_out_ready, c_zero_err;
   logic [3:0]  c_out_idx;

   beat_t exp_q[$];
   int    errors = 0;
   int    checks = 0;

   onehot_encoder_seq #(.N(8), .MSB_FIRST(0), .ONEHOT_ONLY(0)) u_a (
      .clk(clk), .rst_n(rst_n), .in_vec(a_vec), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_idx(a_out_idx), .out_last(a_out_last), .out_multi(a_out_multi), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .zero_err(a_zero_err));

   onehot_encoder_seq #(.N(8), .MSB_FIRST(1), .ONEHOT_ONLY(1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_vec(b_vec), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_idx(b_out_idx), .out_last(b_out_last), .out_multi(b_out_multi), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .zero_err(b_zero_err));

   onehot_encoder_seq #(.N(16), .MSB_FIRST(0), .ONEHOT_ONLY(0)) u_c (
      .clk(clk), .rst_n(rst_n), .in_vec(c_vec), .in_valid(c_in_valid), .in_ready(c_in_ready),
      .out_idx(c_out_idx), .out_last(c_out_last), .out_multi(c_out_multi), .out_valid(c_out_valid),
      .out_ready(c_out_ready), .zero_err(c_zero_err));

   always #5 clk = ~clk;

   // Reference model: list the set bits in priority order and push one expected beat per emitted index.
   function automatic void push_beats(input logic [15:0] v, input int n, input bit msb, input bit oh);
      int    order[$];
      int    pos;
      int    cnt;
      int    lim;
      beat_t bt;
      for (int k = 0; k < n; k++) begin
         pos = msb ? (n - 1 - k) : k;
         if (v[pos]) order.push_back(pos);
      end
      cnt = order.size();
      lim = (oh && cnt > 0) ? 1 : cnt;
      for (int j = 0; j < lim; j++) begin
         bt.idx   = 8'(order[j]);
         bt.last  = (j == lim - 1);
         bt.multi = (cnt > 1);
         exp_q.push_back(bt);
      end
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      checks++;
      if ({a_out_valid, b_out_valid, c_out_valid, a_zero_err, b_zero_err, c_zero_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs: valid a/b/c=%b%b%b zero_err a/b/c=%b%b%b, required all 0",
                  a_out_valid, b_out_valid, c_out_valid, a_zero_err, b_zero_err, c_zero_err);
      end
      rst_n = 1'b1;
      @(negedge clk); #1;
      checks++;
      if ({a_in_ready, b_in_ready, c_in_ready} !== 3'b111 || {a_out_valid, b_out_valid, c_out_valid} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: in_ready=%b%b%b out_valid=%b%b%b, required 111/000",
                  a_in_ready, b_in_ready, c_in_ready, a_out_valid, b_out_valid, c_out_valid);
      end
   endtask

   task automatic test_single();
      beat_t e;
      @(negedge clk);
      a_vec = 8'b0010_0000; a_in_valid = 1'b1; a_out_ready = 1'b1;
      push_beats({8'h00, a_vec}, 8, 1'b0, 1'b0);
      @(negedge clk);
      a_in_valid = 1'b0;
      for (int cyc = 0; cyc < 4 && exp_q.size() > 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         checks++;
         if (a_out_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid: out_valid=%b, required 1", a_out_valid);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if ({a_out_idx, a_out_last, a_out_multi, a_in_ready} !== {e.idx[2:0], e.last, e.multi, 1'b1}) begin
               errors++;
               $display("FAIL single_beat: idx=%0d last=%b multi=%b in_ready=%b, required idx=%0d last=%b multi=%b in_ready=1",
                        a_out_idx, a_out_last, a_out_multi, a_in_ready, e.idx, e.last, e.multi);
            end
         end
      end
      if (exp_q.size() > 0) begin
         checks++; errors++; $display("FAIL single_timeout: %0d beats missing, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
         errors++; $display("FAIL single_idle: out_valid=%b, required 0", a_out_valid);
      end
   endtask

   task automatic test_multi_drain();
      beat_t e;
      bit    sent_next = 1'b0;
      @(negedge clk);
      a_vec = 8'b1001_0010; a_in_valid = 1'b1; a_out_ready = 1'b1;
      push_beats({8'h00, a_vec}, 8, 1'b0, 1'b0);
      @(negedge clk);
      for (int cyc = 0; cyc < 8 && exp_q.size() > 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         a_in_valid = 1'b0;
         #1;
         checks++;
         if (a_out_valid !== 1'b1) begin
            errors++; $display("FAIL multi_valid: cycle %0d out_valid=%b, required 1", cyc, a_out_valid);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if ({a_out_idx, a_out_last, a_out_multi} !== {e.idx[2:0], e.last, e.multi}) begin
               errors++;
               $display("FAIL multi_beat: idx=%0d last=%b multi=%b, required idx=%0d last=%b multi=%b",
                        a_out_idx, a_out_last, a_out_multi, e.idx, e.last, e.multi);
            end
            if (e.last && !sent_next) begin
               sent_next = 1'b1;
               a_vec = 8'b0000_1000; a_in_valid = 1'b1;
               push_beats({8'h00, a_vec}, 8, 1'b0, 1'b0);
               #1;
               checks++;
               if (a_in_ready !== 1'b1) begin
                  errors++; $display("FAIL multi_no_bubble: in_ready=%b on last beat, required 1", a_in_ready);
               end
            end
         end
      end
      a_in_valid = 1'b0;
      if (exp_q.size() > 0) begin
         checks++; errors++; $display("FAIL multi_timeout: %0d beats missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_zero();
      @(negedge clk);
      a_vec = 8'h00; a_in_valid = 1'b1; a_out_ready = 1'b1;
      push_beats({8'h00, a_vec}, 8, 1'b0, 1'b0);
      #1;
      checks++;
      if (a_in_ready !== 1'b1) begin
         errors++; $display("FAIL zero_accept: in_ready=%b, required 1", a_in_ready);
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      #1;
      checks++;
      if ({a_zero_err, a_out_valid, a_in_ready} !== 3'b101 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL zero_pulse: zero_err=%b out_valid=%b in_ready=%b beats=%0d, required 1/0/1/0",
                  a_zero_err, a_out_valid, a_in_ready, exp_q.size());
      end
      @(negedge clk); #1;
      checks++;
      if ({a_zero_err, a_out_valid, a_in_ready} !== 3'b001) begin
         errors++;
         $display("FAIL zero_one_cycle: zero_err=%b out_valid=%b in_ready=%b, required 0/0/1",
                  a_zero_err, a_out_valid, a_in_ready);
      end
   endtask

   task automatic test_backpressure();
      beat_t e;
      @(negedge clk);
      a_vec = 8'b0000_1001; a_in_valid = 1'b1; a_out_ready = 1'b0;
      push_beats({8'h00, a_vec}, 8, 1'b0, 1'b0);
      @(negedge clk);
      a_in_valid = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         e = exp_q[0];
         checks++;
         if ({a_out_valid, a_out_idx, a_out_last, a_out_multi, a_in_ready} !== {1'b1, e.idx[2:0], e.last, e.multi, 1'b0}) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d valid=%b idx=%0d last=%b multi=%b in_ready=%b, required 1/%0d/%b/%b/0",
                     cyc, a_out_valid, a_out_idx, a_out_last, a_out_multi, a_in_ready, e.idx, e.last, e.multi);
         end
      end
      @(negedge clk);
      a_out_ready = 1'b1;
      for (int cyc = 0; cyc < 4 && exp_q.size() > 0; cyc++) begin
         if (cyc > 0) @(negedge clk);
         #1;
         checks++;
         if (a_out_valid !== 1'b1) begin
            errors++; $display("FAIL bp_valid: out_valid=%b, required 1", a_out_valid);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if ({a_out_idx, a_out_last, a_out_multi, a_in_ready} !== {e.idx[2:0], e.last, e.multi, e.last}) begin
               errors++;
               $display("FAIL bp_drain: idx=%0d last=%b multi=%b in_ready=%b, required idx=%0d last=%b multi=%b in_ready=%b",
                        a_out_idx, a_out_last, a_out_multi, a_in_ready, e.idx, e.last, e.multi, e.last);
            end
         end
      end
      if (exp_q.size() > 0) begin
         checks++; errors++; $display("FAIL bp_timeout: %0d beats missing, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_priority_drop();
      beat_t e;
      @(negedge clk);
      b_vec = 8'b0100_0110; b_in_valid = 1'b1; b_out_ready = 1'b1;
      push_beats({8'h00, b_vec}, 8, 1'b1, 1'b1);
      @(negedge clk);
      b_in_valid = 1'b0;
      #1;
      checks++;
      if (b_out_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++; $display("FAIL prio_valid: out_valid=%b, required 1", b_out_valid);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({b_out_idx, b_out_last, b_out_multi} !== {e.idx[2:0], e.last, e.multi}) begin
            errors++;
            $display("FAIL prio_beat: idx=%0d last=%b multi=%b, required idx=%0d last=%b multi=%b",
                     b_out_idx, b_out_last, b_out_multi, e.idx, e.last, e.multi);
         end
      end
      @(negedge clk); #1;
      checks++;
      if ({b_out_valid, b_in_ready} !== 2'b01 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL prio_drop: out_valid=%b in_ready=%b queued=%0d, required 0/1/0", b_out_valid, b_in_ready, exp_q.size());
      end
   endtask

   task automatic test_reset_mid_drain();
      beat_t e;
      int    seen = 0;
      @(negedge clk);
      c_vec = 16'h8001; c_in_valid = 1'b1; c_out_ready = 1'b1;
      push_beats(c_vec, 16, 1'b0, 1'b0);
      @(negedge clk);
      c_in_valid = 1'b0;
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({c_out_valid, c_out_idx, c_out_last, c_out_multi} !== {1'b1, e.idx[3:0], e.last, e.multi}) begin
         errors++;
         $display("FAIL midrst_first: valid=%b idx=%0d last=%b multi=%b, required 1/%0d/%b/%b",
                  c_out_valid, c_out_idx, c_out_last, c_out_multi, e.idx, e.last, e.multi);
      end
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if ({c_out_valid, c_in_ready} !== 2'b01) begin
         errors++; $display("FAIL midrst_cleared: out_valid=%b in_ready=%b, required 0/1", c_out_valid, c_in_ready);
      end
      for (int cyc = 0; cyc < 4; cyc++) begin
         @(negedge clk); #1;
         if (c_out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++; $display("FAIL midrst_no_idx15: %0d stray beats after reset, required 0", seen);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      a_vec = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      b_vec = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
      c_vec = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
      test_reset();
      test_single();
      test_multi_drain();
      test_zero();
      test_backpressure();
      test_priority_drop();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
